// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/redirect controller with in-flight store tracker for load-after-store stalls.
// Optional stall watchdog enabled by defining PIPE_WATCHDOG_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 7,
  parameter int unsigned MEM_STAGE  = 4,
  parameter int unsigned EXC_STAGE  = 4,
  parameter int unsigned SB_DEPTH   = 4,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned WD_LIMIT   = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  input  logic                  exc_flush,
  input  logic                  ld_req,
  input  logic [31:0]           ld_addr,
  input  logic                  ld_cached,
  input  logic                  st_issue,
  input  logic [31:0]           st_addr,
  input  logic                  st_ack,
  output logic [NUM_STAGES-1:0] stage_wr,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_diswr,
  output logic                  ireq_valid,
  output logic                  dreq_valid,
  output logic                  icache_stall,
  output logic                  dcache_stall,
  output logic                  sb_full,
  output logic                  wd_timeout
);

  localparam int unsigned LINE_LSB = $clog2(LINE_BYTES);
  localparam int unsigned LINE_W   = 32 - LINE_LSB;
  localparam int unsigned PTR_W    = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  if (NUM_STAGES < 3 || (SB_DEPTH & (SB_DEPTH - 1)) != 0 || SB_DEPTH < 2 ||
      WD_LIMIT == 0 || WD_LIMIT > 1023) begin : g_bad_param
    $error("pipe_hazard_ctrl: illegal parameter combination");
  end

  function automatic int unsigned deepest(input logic [NUM_STAGES-1:0] v);
    deepest = 0;
    for (int unsigned i = 0; i < NUM_STAGES; i++)
      if (v[i]) deepest = i;
  endfunction

  logic              sb_valid [SB_DEPTH];
  logic [LINE_W-1:0] sb_line  [SB_DEPTH];
  logic [PTR_W-1:0]  sb_head, sb_tail;
  logic [CNT_W-1:0]  sb_count;
  logic [NUM_STAGES-1:0] pend_vec, pend_nxt, redir_vec;

  logic        sb_empty, push, pop, ld_match, hazard, stall_eff, redir_any;
  int unsigned stall_k, redir_k;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{ld_addr[LINE_LSB-1:0], st_addr[LINE_LSB-1:0]};

  assign sb_full  = (sb_count == CNT_W'(SB_DEPTH));
  assign sb_empty = (sb_count == '0);
  assign pop      = st_ack & ~sb_empty;
  // A full tracker still accepts a store when the oldest one retires in the same cycle.
  assign push     = st_issue & (~sb_full | pop);

  always_comb begin
    ld_match = 1'b0;
    for (int unsigned e = 0; e < SB_DEPTH; e++)
      if (sb_valid[e] && sb_line[e] == ld_addr[31:LINE_LSB]) ld_match = 1'b1;
  end

  assign hazard    = (ld_req & ld_cached & ld_match) | (st_issue & sb_full);
  assign stall_eff = (|stall_req) | hazard;
  assign redir_vec = flush_req | pend_vec;
  assign redir_any = |redir_vec;

  // Next-state of the pending redirect plus all control outputs.
  always_comb begin
    stall_k      = (|stall_req) ? deepest(stall_req) : MEM_STAGE;
    redir_k      = deepest(redir_vec);
    pend_nxt     = pend_vec;
    stage_wr     = '1;
    stage_flush  = '0;
    stage_diswr  = '0;
    ireq_valid   = 1'b1;
    dreq_valid   = 1'b1;
    icache_stall = 1'b0;
    dcache_stall = 1'b0;
    if (rst) begin
      stage_wr    = '0;
      stage_flush = '1;
      stage_diswr = '1;
      ireq_valid  = 1'b0;
      dreq_valid  = 1'b0;
    end else if (exc_flush) begin
      pend_nxt   = '0;
      ireq_valid = 1'b0;
      dreq_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_flush[i] = (i >= 1) && (i <= EXC_STAGE);
        stage_diswr[i] = (i >= 1) && (i <= EXC_STAGE);
      end
    end else if (stall_eff) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_wr[i]    = (i > stall_k);
        stage_flush[i] = (i == stall_k + 1);
        stage_diswr[i] = (i <= stall_k);
        if (redir_any) pend_nxt[i] = (i == redir_k);
      end
      icache_stall = 1'b1;
      dcache_stall = (stall_k >= MEM_STAGE);
      ireq_valid   = ~stall_req[0];
      dreq_valid   = ~(stall_k >= MEM_STAGE);
    end else if (redir_any) begin
      pend_nxt   = '0;
      ireq_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_STAGES; i++)
        stage_flush[i] = (i >= 1) && (i < redir_k);
    end
  end

  // Tracker FIFO and pending redirect; pop is applied before push so a full-FIFO swap keeps the new entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < SB_DEPTH; e++) begin
        sb_valid[e] <= 1'b0;
        sb_line[e]  <= '0;
      end
      sb_head  <= '0;
      sb_tail  <= '0;
      sb_count <= '0;
      pend_vec <= '0;
    end else begin
      if (pop) begin
        sb_valid[sb_head] <= 1'b0;
        sb_head           <= sb_head + PTR_W'(1);
      end
      if (push) begin
        sb_valid[sb_tail] <= 1'b1;
        sb_line[sb_tail]  <= st_addr[31:LINE_LSB];
        sb_tail           <= sb_tail + PTR_W'(1);
      end
      sb_count <= sb_count + CNT_W'(push) - CNT_W'(pop);
      pend_vec <= pend_nxt;
    end
  end

`ifdef PIPE_WATCHDOG_EN
  logic [9:0] wd_cnt;
  logic       wd_stall, wd_hit;

  assign wd_stall   = stall_eff & ~exc_flush;
  assign wd_hit     = wd_stall && (wd_cnt == 10'(WD_LIMIT - 1));
  assign wd_timeout = wd_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     wd_cnt <= '0;
    else if (!wd_stall || wd_hit) wd_cnt <= '0;
    else                         wd_cnt <= wd_cnt + 10'd1;
  end
`else
  assign wd_timeout = 1'b0;
`endif

endmodule
